// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// mem_access_unit_pkg : op codes and FSM states for the MEM-stage unit
// Revision 1.0
// ============================================================================
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2,
    MS_DONE = 2'd3
  } ms_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_gen.sv
`default_nettype none
// ============================================================================
// mem_lane_gen : op + addr[1:0] + store data -> legality, misalign, byte
//                enables and lane-replicated write data (combinational)
// Revision 1.0
// ============================================================================
module mem_lane_gen
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic        o_legal,
  output logic        o_store,
  output logic        o_misalign,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_legal    = 1'b1;
    o_store    = 1'b0;
    o_misalign = 1'b0;
    o_we       = 4'b0000;
    o_wdata    = 32'h0;
    case (mem_op_e'(i_op))
      MEM_LB, MEM_LBU: ;
      MEM_LH, MEM_LHU: o_misalign = i_addr_lo[0];
      MEM_LW:          o_misalign = |i_addr_lo;
      MEM_SB: begin
        o_store = 1'b1;
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEM_SH: begin
        o_store    = 1'b1;
        o_misalign = i_addr_lo[0];
        o_we       = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
      end
      MEM_SW: begin
        o_store    = 1'b1;
        o_misalign = |i_addr_lo;
        o_we       = 4'b1111;
        o_wdata    = i_wdata;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage load/store engine with DRAM req/gnt/rvalid
//                   handshake, misalignment (ALE) and bus-timeout detection
// Revision 1.0
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic [2:0]  i_ex_op,
  input  logic [31:0] i_ex_addr,
  input  logic [31:0] i_ex_wdata,
  output logic        o_dram_req,
  output logic [3:0]  o_dram_we,
  output logic [31:0] o_dram_addr,
  output logic [31:0] o_dram_wdata,
  input  logic        i_dram_gnt,
  input  logic        i_dram_rvalid,
  input  logic [31:0] i_dram_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_rdata,
  output logic [1:0]  o_wb_addr_lo,
  output logic [2:0]  o_wb_op,
  output logic        o_ale,
  output logic        o_bus_err,
  output logic        o_stall
);

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  ms_state_e   r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_op;
  logic [29:0] r_addr_hi;
  logic [1:0]  r_addr_lo;
  logic        r_store;
  logic [3:0]  r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_ale;
  logic        r_bus_err;

  logic        w_legal;
  logic        w_store;
  logic        w_misalign;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic        w_accept;

  mem_lane_gen u_lane_gen (
    .i_op       (i_ex_op),
    .i_addr_lo  (i_ex_addr[1:0]),
    .i_wdata    (i_ex_wdata),
    .o_legal    (w_legal),
    .o_store    (w_store),
    .o_misalign (w_misalign),
    .o_we       (w_we),
    .o_wdata    (w_wdata)
  );

  assign w_accept = i_ex_valid & (r_state == MS_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MS_IDLE;
      r_cnt     <= 8'd0;
      r_op      <= 3'd0;
      r_addr_hi <= 30'd0;
      r_addr_lo <= 2'd0;
      r_store   <= 1'b0;
      r_we      <= 4'd0;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_ale     <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_ale     <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        MS_IDLE: begin
          // Illegal op codes fall through both branches and act as a NOP.
          if (w_accept && w_legal && w_misalign) begin
            r_ale <= 1'b1;
          end else if (w_accept && w_legal) begin
            r_op      <= i_ex_op;
            r_addr_hi <= i_ex_addr[31:2];
            r_addr_lo <= i_ex_addr[1:0];
            r_store   <= w_store;
            r_we      <= w_we;
            r_wdata   <= w_wdata;
            r_rdata   <= 32'h0;
            r_state   <= MS_REQ;
          end
        end
        MS_REQ: begin
          if (i_dram_gnt) begin
            if (r_store) begin
              r_state <= MS_DONE;
            end else if (i_dram_rvalid) begin
              r_rdata <= i_dram_rdata;
              r_state <= MS_DONE;
            end else begin
              r_cnt   <= 8'd0;
              r_state <= MS_WAIT;
            end
          end
        end
        MS_WAIT: begin
          // A late rvalid on the final counted cycle still wins over the timeout.
          if (i_dram_rvalid) begin
            r_rdata <= i_dram_rdata;
            r_state <= MS_DONE;
          end else if (r_cnt == c_TO_LAST) begin
            r_bus_err <= 1'b1;
            r_rdata   <= 32'h0;
            r_state   <= MS_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        MS_DONE: r_state <= MS_IDLE;
        default: r_state <= MS_IDLE;
      endcase
    end
  end

  assign o_ex_ready   = (r_state == MS_IDLE);
  assign o_dram_req   = (r_state == MS_REQ);
  assign o_dram_we    = o_dram_req ? r_we : 4'b0000;
  assign o_dram_addr  = {r_addr_hi, 2'b00};
  assign o_dram_wdata = r_wdata;
  assign o_wb_valid   = (r_state == MS_DONE);
  assign o_wb_rdata   = r_rdata;
  assign o_wb_addr_lo = r_addr_lo;
  assign o_wb_op      = r_op;
  assign o_ale        = r_ale;
  assign o_bus_err    = r_bus_err;
  assign o_stall      = (r_state == MS_REQ) | (r_state == MS_WAIT) |
                        (w_accept & w_legal & ~w_misalign);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : directed + randomized checks against a byte-level
//                      reference model of the MEM-stage unit
// Revision 1.0
// ============================================================================
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO   = 16;
  localparam int NCYC = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [2:0]  ex_op = 3'd0;
  logic [31:0] ex_addr = 32'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic        dram_req;
  logic [3:0]  dram_we;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_gnt = 1'b0;
  logic        dram_rvalid = 1'b0;
  logic [31:0] dram_rdata = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_rdata;
  logic [1:0]  wb_addr_lo;
  logic [2:0]  wb_op;
  logic        ale;
  logic        bus_err;
  logic        stall;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ex_valid   (ex_valid),
    .o_ex_ready   (ex_ready),
    .i_ex_op      (ex_op),
    .i_ex_addr    (ex_addr),
    .i_ex_wdata   (ex_wdata),
    .o_dram_req   (dram_req),
    .o_dram_we    (dram_we),
    .o_dram_addr  (dram_addr),
    .o_dram_wdata (dram_wdata),
    .i_dram_gnt   (dram_gnt),
    .i_dram_rvalid(dram_rvalid),
    .i_dram_rdata (dram_rdata),
    .o_wb_valid   (wb_valid),
    .o_wb_rdata   (wb_rdata),
    .o_wb_addr_lo (wb_addr_lo),
    .o_wb_op      (wb_op),
    .o_ale        (ale),
    .o_bus_err    (bus_err),
    .o_stall      (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int op_size(input logic [2:0] op);
    if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
    return 4;
  endfunction

  function automatic bit op_is_store(input logic [2:0] op);
    return (op == MEM_SB || op == MEM_SH || op == MEM_SW);
  endfunction

  // One op through the unit with a scripted bus: gnt after gdly extra REQ
  // cycles, rvalid rdly cycles after gnt (rdly<0: never). Cycle 0 = accept.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int gdly, input int rdly,
                        input logic [31:0] rd, input string tag);
    int sz, exp_wb, exp_req, req_k, gnt_n, req_n, ale_n, err_n, rdy_lo, wb_n, wb_extra;
    bit st, mis, tmo;
    logic [3:0]  exp_we, we_s;
    logic [31:0] exp_wd, exp_rd, ad_s, wd_s, rd_s;
    logic [1:0]  lo_s;
    logic [2:0]  op_s;
    logic        stall0, stall_dn;
    sz  = op_size(op);
    st  = op_is_store(op);
    mis = (addr % sz) != 0;
    tmo = !st && !mis && (rdly < 0 || rdly > TO);
    exp_we = 4'b0000;
    exp_wd = 32'h0;
    if (st) begin
      for (int b = 0; b < sz; b++) exp_we[(addr % 4) + b] = 1'b1;
      for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wd[8*(b % sz) +: 8];
    end
    if (mis)                  exp_wb = -1;
    else if (st || rdly == 0) exp_wb = gdly + 2;
    else if (tmo)             exp_wb = gdly + 2 + TO;
    else                      exp_wb = gdly + 2 + rdly;
    exp_req = mis ? 0 : gdly + 1;
    exp_rd  = (!st && !mis && !tmo) ? rd : 32'h0;

    req_k = 0; gnt_n = -1; req_n = 0; ale_n = 0; err_n = 0; rdy_lo = 0;
    wb_n = -1; wb_extra = 0;
    we_s = 4'h0; ad_s = 32'h0; wd_s = 32'h0; rd_s = 32'h0; lo_s = 2'd0; op_s = 3'd0;
    stall_dn = 1'b1;

    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wd;
    @(negedge clk);
    stall0 = stall;
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_at_accept: got %b want 1", tag, ex_ready);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = 3'($urandom); ex_addr = $urandom; ex_wdata = $urandom;
    for (int n = 1; n <= NCYC; n++) begin
      dram_gnt = 1'b0; dram_rvalid = 1'b0; dram_rdata = $urandom;
      if (dram_req) begin
        if (req_k == gdly) begin dram_gnt = 1'b1; gnt_n = n; end
        req_k++;
      end
      if (rdly >= 0 && gnt_n >= 0 && n == gnt_n + rdly) begin
        dram_rvalid = 1'b1; dram_rdata = rd;
      end
      @(negedge clk);
      if (dram_req) begin req_n++; we_s = dram_we; ad_s = dram_addr; wd_s = dram_wdata; end
      if (ale) ale_n++;
      if (bus_err) err_n++;
      if (!ex_ready) rdy_lo++;
      if (wb_valid) begin
        if (wb_n < 0) begin
          wb_n = n; rd_s = wb_rdata; lo_s = wb_addr_lo; op_s = wb_op; stall_dn = stall;
        end else wb_extra++;
      end
      @(posedge clk); #1;
    end
    dram_gnt = 1'b0; dram_rvalid = 1'b0;

    checks++;
    if (wb_n != exp_wb) begin failures++; $display("FAIL %s wb_cycle: got %0d want %0d", tag, wb_n, exp_wb); end
    checks++;
    if (wb_extra != 0) begin failures++; $display("FAIL %s wb_extra_pulses: got %0d want 0", tag, wb_extra); end
    checks++;
    if (ale_n != int'(mis)) begin failures++; $display("FAIL %s ale_pulses: got %0d want %0d", tag, ale_n, mis); end
    checks++;
    if (err_n != int'(tmo)) begin failures++; $display("FAIL %s bus_err_pulses: got %0d want %0d", tag, err_n, tmo); end
    checks++;
    if (req_n != exp_req) begin failures++; $display("FAIL %s req_cycles: got %0d want %0d", tag, req_n, exp_req); end
    checks++;
    if (rdy_lo != (mis ? 0 : exp_wb)) begin
      failures++; $display("FAIL %s ready_low_cycles: got %0d want %0d", tag, rdy_lo, mis ? 0 : exp_wb);
    end
    checks++;
    if (stall0 !== !mis) begin failures++; $display("FAIL %s stall_at_accept: got %b want %b", tag, stall0, !mis); end
    if (!mis) begin
      checks++;
      if (rd_s !== exp_rd) begin failures++; $display("FAIL %s wb_rdata: got %h want %h", tag, rd_s, exp_rd); end
      checks++;
      if (lo_s !== 2'(addr % 4)) begin failures++; $display("FAIL %s wb_addr_lo: got %0d want %0d", tag, lo_s, addr % 4); end
      checks++;
      if (op_s !== op) begin failures++; $display("FAIL %s wb_op: got %0d want %0d", tag, op_s, op); end
      checks++;
      if (stall_dn !== 1'b0) begin failures++; $display("FAIL %s stall_in_done: got %b want 0", tag, stall_dn); end
      checks++;
      if (ad_s !== (addr / 4) * 4) begin failures++; $display("FAIL %s dram_addr: got %h want %h", tag, ad_s, (addr / 4) * 4); end
      checks++;
      if (we_s !== exp_we) begin failures++; $display("FAIL %s dram_we: got %b want %b", tag, we_s, exp_we); end
      if (st) begin
        checks++;
        if (wd_s !== exp_wd) begin failures++; $display("FAIL %s dram_wdata: got %h want %h", tag, wd_s, exp_wd); end
      end
      checks++;
      if (wb_rdata !== exp_rd) begin failures++; $display("FAIL %s wb_rdata_hold: got %h want %h", tag, wb_rdata, exp_rd); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset ex_ready: got %b want 1", ex_ready); end
    checks++;
    if ({dram_req, dram_we, dram_addr, dram_wdata} !== 69'h0) begin
      failures++; $display("FAIL reset dram_outputs: got req=%b we=%b addr=%h wd=%h want 0", dram_req, dram_we, dram_addr, dram_wdata);
    end
    checks++;
    if ({wb_valid, wb_rdata, wb_addr_lo, wb_op, ale, bus_err, stall} !== 41'h0) begin
      failures++; $display("FAIL reset wb_outputs: got v=%b rd=%h lo=%0d op=%0d ale=%b err=%b stall=%b want 0",
                           wb_valid, wb_rdata, wb_addr_lo, wb_op, ale, bus_err, stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(MEM_SB, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, "sb_lane3");
    run_op(MEM_LH, 32'h0000_2002, 32'h0, 2, 1, 32'hBEEF_1234, "lh_slow_gnt");
    run_op(MEM_LW, 32'h0000_3001, 32'h1234_5678, 0, 1, 32'h0, "lw_misaligned");
    run_op(MEM_LW, 32'h0000_4000, 32'h0, 0, 0, 32'hCAFE_F00D, "lw_gnt_rvalid");
    run_op(MEM_LB, 32'h0000_5001, 32'h0, 0, -1, 32'hDEAD_BEEF, "lb_timeout");
    run_op(MEM_LBU, 32'h0000_5002, 32'h0, 1, TO, 32'h0BAD_F00D, "lbu_last_cycle");
    run_op(MEM_SH, 32'h0000_6002, 32'hFFFF_9876, 1, 0, 32'h0, "sh_upper");
    run_op(MEM_SH, 32'h0000_6003, 32'hFFFF_9876, 0, 0, 32'h0, "sh_misaligned");
    run_op(MEM_SW, 32'h0000_7000, 32'h0102_0304, 0, 0, 32'h0, "sw_full");
    run_op(MEM_LHU, 32'h0000_8001, 32'h0, 0, 1, 32'h0, "lhu_misaligned");
  endtask

  task automatic test_reset_mid();
    int wb_seen;
    ex_valid = 1'b1; ex_op = MEM_LW; ex_addr = 32'h0000_9000; ex_wdata = 32'h0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dram_gnt = 1'b1;
    @(posedge clk); #1;
    dram_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1 || dram_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 ||
        wb_rdata !== 32'h0 || dram_addr !== 32'h0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid outputs: got ready=%b req=%b stall=%b wbv=%b rd=%h addr=%h err=%b want ready=1 rest 0",
                           ex_ready, dram_req, stall, wb_valid, wb_rdata, dram_addr, bus_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_seen = 0;
    for (int n = 0; n < TO + 4; n++) begin
      @(negedge clk);
      if (wb_valid || bus_err) wb_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (wb_seen != 0) begin failures++; $display("FAIL reset_mid wb_after_release: got %0d pulses want 0", wb_seen); end
  endtask

  task automatic test_random();
    int r, rdly;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rdly = -1;
      else if (r == 1) rdly = TO + 1;
      else if (r == 2) rdly = TO;
      else             rdly = r - 3;
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3), rdly, $urandom,
             $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
